// File: rtl/vram_arbiter_if.sv
// Bus bundle between the vram arbiter, the CPU pixel-write path, the VGA fetch path
// and the single-port video RAM.
interface vram_arbiter_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // CPU write port: a write transfers on a rising edge where iCpuValid && oCpuReady;
  // while oCpuReady is low the CPU holds iCpuValid/iCpuAddr/iCpuData stable.
  logic              iCpuValid;
  logic [ADDR_W-1:0] iCpuAddr;
  logic [DATA_W-1:0] iCpuData;
  logic              oCpuReady;

  logic              iVidReq;
  logic [ADDR_W-1:0] iVidAddr;
  logic [DATA_W-1:0] oVidData;
  logic              oVidValid;

  logic [ADDR_W-1:0] oRamAddr;
  logic              oRamWe;
  logic [DATA_W-1:0] oRamData;
  logic [DATA_W-1:0] iRamData;

  logic [LVL_W-1:0]  oFifoLevel;
  logic [1:0]        oDbgGrant;

  modport slave (
    input  iCpuValid, iCpuAddr, iCpuData, iVidReq, iVidAddr, iRamData,
    output oCpuReady, oVidData, oVidValid, oRamAddr, oRamWe, oRamData,
    output oFifoLevel, oDbgGrant
  );

  modport master (
    output iCpuValid, iCpuAddr, iCpuData, iVidReq, iVidAddr, iRamData,
    input  oCpuReady, oVidData, oVidValid, oRamAddr, oRamWe, oRamData,
    input  oFifoLevel, oDbgGrant
  );
endinterface

// File: rtl/vram_arbiter.sv
// Video-priority arbiter for the single-port video RAM; CPU pixel writes are
// buffered in a small FIFO and drained into cycles the scan-out does not use.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic            Clock,
  input logic            Reset,
  vram_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VID  = 2'd1,
    G_CPU  = 2'd2
  } grant_t;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  grant_t            r_grant;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_data;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_vid_valid;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;

  // Ready comes only from the stored level, so a pop on the same edge never
  // admits an extra write and an empty FIFO never forwards straight to the RAM.
  assign w_ready = (r_level < LVL_W'(FIFO_DEPTH));
  assign w_push  = bus.iCpuValid && w_ready;
  assign w_pop   = !bus.iVidReq && (r_level != '0);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.iCpuAddr, bus.iCpuData};
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Grant records what the RAM port does during the next cycle; a fetch issued
  // under G_VID has its read data on iRamData for the following edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_grant     <= G_NONE;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_data  <= '0;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
    end else begin
      r_vid_valid <= (r_grant == G_VID);
      if (r_grant == G_VID) begin
        r_vid_data <= bus.iRamData;
      end

      if (bus.iVidReq) begin
        r_grant    <= G_VID;
        r_ram_addr <= bus.iVidAddr;
        r_ram_we   <= 1'b0;
      end else if (w_pop) begin
        r_grant    <= G_CPU;
        r_ram_addr <= w_head[ENT_W-1:DATA_W];
        r_ram_data <= w_head[DATA_W-1:0];
        r_ram_we   <= 1'b1;
      end else begin
        r_grant    <= G_NONE;
        r_ram_we   <= 1'b0;
      end
    end
  end

  assign bus.oCpuReady  = w_ready;
  assign bus.oFifoLevel = r_level;
  assign bus.oRamAddr   = r_ram_addr;
  assign bus.oRamWe     = r_ram_we;
  assign bus.oRamData   = r_ram_data;
  assign bus.oVidData   = r_vid_data;
  assign bus.oVidValid  = r_vid_valid;
  assign bus.oDbgGrant  = r_grant;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a vector table for fetch latency and CPU drain,
// then hand sequences for priority/full, pointer wrap, no-forwarding and mid-run reset.
module tb_vram_arbiter;
  logic clk;
  logic rst_n;

  vram_arbiter_if #(.ADDR_W(16), .DATA_W(3), .FIFO_DEPTH(4)) bus ();

  vram_arbiter #(.ADDR_W(16), .DATA_W(3), .FIFO_DEPTH(4)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  logic [2:0] ram [0:65535];
  assign bus.iRamData = ram[bus.oRamAddr];
  always @(posedge clk) begin
    if (bus.oRamWe) ram[bus.oRamAddr] = bus.oRamData;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: note whether the CPU offer is accepted, advance, then check any RAM write.
  task automatic step(output logic accepted);
    logic [18:0] ent;
    accepted = bus.iCpuValid && bus.oCpuReady;
    ent = {bus.iCpuAddr, bus.iCpuData};
    @(posedge clk);
    #1;
    if (accepted) exp_q.push_back(ent);
    if (bus.oRamWe === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h expected none", {bus.oRamAddr, bus.oRamData});
      end else begin
        chk("write_order", {13'd0, bus.oRamAddr, bus.oRamData}, {13'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic drive(input logic vreq, input logic [15:0] vaddr,
                       input logic cval, input logic [15:0] caddr, input logic [2:0] cdata);
    bus.iVidReq   = vreq;
    bus.iVidAddr  = vaddr;
    bus.iCpuValid = cval;
    bus.iCpuAddr  = caddr;
    bus.iCpuData  = cdata;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"},   32'(bus.oRamAddr),   32'd0);
    chk({tag, "_we"},     32'(bus.oRamWe),     32'd0);
    chk({tag, "_wdata"},  32'(bus.oRamData),   32'd0);
    chk({tag, "_vdata"},  32'(bus.oVidData),   32'd0);
    chk({tag, "_vvalid"}, 32'(bus.oVidValid),  32'd0);
    chk({tag, "_level"},  32'(bus.oFifoLevel), 32'd0);
    chk({tag, "_ready"},  32'(bus.oCpuReady),  32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        vreq;
    logic [15:0] vaddr;
    logic        cval;
    logic [15:0] caddr;
    logic [2:0]  cdata;
    logic        e_we;
    logic [15:0] e_addr;
    logic [2:0]  e_wdata;
    logic        e_vvalid;
    logic [2:0]  e_vdata;
    logic [2:0]  e_level;
    logic        e_ready;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic a;
    int acc;
    logic [15:0] wa [6];
    logic [2:0]  wd [6];
    int w0;
    int bound;

    for (int i = 0; i < 65536; i++) ram[i] = 3'd0;
    ram[16'h0010] = 3'b101;
    for (int i = 0; i < 16; i++) ram[16'h0100 + i] = i[2:0];

    //        vreq vaddr   cval caddr  cd   | we addr    wd   vv vd   lvl rdy
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1};
    vecs[1]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0010, 3'd0, 1'b0, 3'd0, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0010, 3'd0, 1'b1, 3'd5, 3'd0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0010, 3'd0, 1'b0, 3'd5, 3'd0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 3'd1, 1'b0, 16'h0010, 3'd0, 1'b0, 3'd5, 3'd1, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 3'd2, 1'b1, 16'h0001, 3'd1, 1'b0, 3'd5, 3'd1, 1'b1};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0003, 3'd3, 1'b1, 16'h0002, 3'd2, 1'b0, 3'd5, 3'd1, 1'b1};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 16'h0004, 3'd4, 1'b1, 16'h0003, 3'd3, 1'b0, 3'd5, 3'd1, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h0004, 3'd4, 1'b0, 3'd5, 3'd0, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0004, 3'd4, 1'b0, 3'd5, 3'd0, 1'b1};
    vecs[10] = '{1'b1, 16'h0004, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0004, 3'd4, 1'b0, 3'd5, 3'd0, 1'b1};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0004, 3'd4, 1'b1, 3'd4, 3'd0, 1'b1};

    // ---- power-on reset ----
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    #3 rst_n = 1'b1;

    // ---- table: fetch latency and CPU drain ----
    foreach (vecs[i]) begin
      drive(vecs[i].vreq, vecs[i].vaddr, vecs[i].cval, vecs[i].caddr, vecs[i].cdata);
      step(a);
      chk($sformatf("v%0d_we", i),     32'(bus.oRamWe),     32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i),   32'(bus.oRamAddr),   32'(vecs[i].e_addr));
      chk($sformatf("v%0d_wdata", i),  32'(bus.oRamData),   32'(vecs[i].e_wdata));
      chk($sformatf("v%0d_vvalid", i), 32'(bus.oVidValid),  32'(vecs[i].e_vvalid));
      chk($sformatf("v%0d_vdata", i),  32'(bus.oVidData),   32'(vecs[i].e_vdata));
      chk($sformatf("v%0d_level", i),  32'(bus.oFifoLevel), 32'(vecs[i].e_level));
      chk($sformatf("v%0d_ready", i),  32'(bus.oCpuReady),  32'(vecs[i].e_ready));
    end

    // ---- priority and full: video held for 10 cycles, 6 writes offered ----
    for (int j = 0; j < 6; j++) begin
      wa[j] = 16'h0200 + 16'(j);
      wd[j] = 3'(j + 1);
    end
    acc = 0;
    w0 = n_writes;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 16'h0100 + 16'(c), acc < 6, wa[acc % 6], wd[acc % 6]);
      step(a);
      if (a) acc++;
      chk("full_we", 32'(bus.oRamWe), 32'd0);
      if (c > 0) begin
        chk("full_vvalid", 32'(bus.oVidValid), 32'd1);
        chk("full_vdata", 32'(bus.oVidData), 32'((c - 1) & 7));
      end
    end
    chk("full_level", 32'(bus.oFifoLevel), 32'd4);
    chk("full_ready", 32'(bus.oCpuReady), 32'd0);
    chk("full_accepts", 32'(acc), 32'd4);
    bound = 0;
    while ((acc < 6 || exp_q.size() != 0) && bound < 30) begin
      drive(1'b0, 16'h0, acc < 6, wa[acc % 6], wd[acc % 6]);
      step(a);
      if (a) acc++;
      bound++;
    end
    chk("full_drain_done", 32'(bound < 30), 32'd1);
    chk("full_total_writes", 32'(n_writes - w0), 32'd6);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    step(a);
    chk("full_level_end", 32'(bus.oFifoLevel), 32'd0);

    // ---- simultaneous push/pop at level 2, across the pointer wrap ----
    w0 = n_writes;
    drive(1'b1, 16'h0010, 1'b1, 16'h0300, 3'd1);
    step(a);
    drive(1'b1, 16'h0010, 1'b1, 16'h0301, 3'd2);
    step(a);
    chk("pp_level_built", 32'(bus.oFifoLevel), 32'd2);
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 16'h0, 1'b1, 16'h0302 + 16'(j), 3'(j + 3));
      step(a);
      chk("pp_accept", 32'(a), 32'd1);
      chk("pp_level", 32'(bus.oFifoLevel), 32'd2);
      chk("pp_we", 32'(bus.oRamWe), 32'd1);
    end
    drive(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    bound = 0;
    while (exp_q.size() != 0 && bound < 10) begin
      step(a);
      bound++;
    end
    chk("pp_drain_done", 32'(bound < 10), 32'd1);
    chk("pp_total_writes", 32'(n_writes - w0), 32'd7);
    step(a);
    chk("pp_level_end", 32'(bus.oFifoLevel), 32'd0);
    chk("pp_we_end", 32'(bus.oRamWe), 32'd0);

    // ---- no forwarding ----
    drive(1'b1, 16'h0020, 1'b1, 16'h0020, 3'b111);
    step(a);
    chk("nf_level", 32'(bus.oFifoLevel), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    step(a);
    chk("nf_vvalid_old", 32'(bus.oVidValid), 32'd1);
    chk("nf_vdata_old", 32'(bus.oVidData), 32'd0);
    chk("nf_we", 32'(bus.oRamWe), 32'd1);
    step(a);
    chk("nf_we_done", 32'(bus.oRamWe), 32'd0);
    drive(1'b1, 16'h0020, 1'b0, 16'h0, 3'd0);
    step(a);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    step(a);
    chk("nf_vvalid_new", 32'(bus.oVidValid), 32'd1);
    chk("nf_vdata_new", 32'(bus.oVidData), 32'd7);

    // ---- reset mid-stream: 3 queued writes, fetch in flight ----
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 16'h0010, 1'b1, 16'h0400 + 16'(j), 3'(j + 1));
      step(a);
    end
    chk("mr_level_pre", 32'(bus.oFifoLevel), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mr");
    exp_q.delete();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 3'd0);
    step(a);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(a);
      chk("mr_post_vvalid", 32'(bus.oVidValid), 32'd0);
      chk("mr_post_we", 32'(bus.oRamWe), 32'd0);
      chk("mr_post_level", 32'(bus.oFifoLevel), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the MiniAlu pixel-write path (CPU side) and the VGA scan-out fetch path (video side). The video side has absolute priority, so scan-out never misses a fetch. CPU writes are buffered in a small FIFO and drained into idle RAM cycles. The block sits between the ALU's write-ROM/pixel datapath, the display timing generator and the video RAM instance.

## Interface
Parameters:
- ADDR_W, 16, video RAM address width
- DATA_W, 3, pixel width (RGB)
- FIFO_DEPTH, 4, CPU write buffer entries (power of two, ≥2)

Ports:
- Clock  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- iCpuValid  in  1  CPU write request
- iCpuAddr  in  ADDR_W  CPU write address
- iCpuData  in  DATA_W  CPU write pixel
- oCpuReady  out  1  FIFO can accept a write this cycle
- iVidReq  in  1  video fetch request
- iVidAddr  in  ADDR_W  video fetch address
- oVidData  out  DATA_W  fetched pixel
- oVidValid  out  1  oVidData valid this cycle
- oRamAddr  out  ADDR_W  registered RAM address
- oRamWe  out  1  registered RAM write enable
- oRamData  out  DATA_W  registered RAM write data
- iRamData  in  DATA_W  RAM read data, one-cycle synchronous read latency
- oFifoLevel  out  clog2(FIFO_DEPTH)+1  occupied FIFO entries

## Operation
- CPU handshake: a write is accepted at a rising edge when iCpuValid && oCpuReady.
  - oCpuReady = (oFifoLevel < FIFO_DEPTH), purely from the current level; a same-cycle pop does not raise ready.
  - When ready is low, the CPU holds its request stable; nothing is dropped.
- FIFO: circular buffer with read and write pointers wrapping modulo FIFO_DEPTH.
  - Push and pop on the same edge leave the level unchanged.
- Grant state register, one of G_NONE, G_VID, G_CPU. It records what the RAM port does in the next cycle. Evaluated at every edge:
  - iVidReq=1 → G_VID. oRamAddr←iVidAddr, oRamWe←0.
  - else, FIFO non-empty → G_CPU. Pop the head; oRamAddr/oRamData←head; oRamWe←1.
  - else → G_NONE. oRamWe←0; oRamAddr and oRamData hold their values.
- Read return: a 1-bit pipeline flag follows G_VID. One cycle after G_VID is entered, oVidData←iRamData and oVidValid←1; otherwise oVidValid←0. oVidData holds its last value when not valid.
- No forwarding: a video fetch to an address whose write is still in the FIFO returns the old RAM contents. The CPU software is responsible for ordering.
- Continuous iVidReq starves CPU writes indefinitely. The FIFO fills and oCpuReady drops; this is the required behaviour.

## Timing
- Reset (asynchronous assert, synchronous-release usage):
  - outputs: oRamAddr=0, oRamWe=0, oRamData=0, oVidData=0, oVidValid=0, oFifoLevel=0, oCpuReady=1.
  - internal: grant=G_NONE; pointers cleared.
- Reset asserted mid-operation clears everything immediately:
  - queued writes are discarded;
  - an in-flight fetch never produces oVidValid.
- Video latency: iVidReq sampled at edge k → oRamAddr valid in cycle k..k+1 → oVidValid=1 after edge k+1, for exactly one cycle per request.
- Back-to-back video requests give one oVidValid per cycle, in request order.
- CPU write latency: accepted at edge k into an empty FIFO with iVidReq=0 at edge k+1 → oRamWe=1 after edge k+1. Minimum write latency is 2 edges.
- Accept-and-pop in the same cycle with an empty FIFO is not allowed: a write is always stored before it is issued.
- oFifoLevel updates on the edge of the push or pop. oCpuReady is combinational from the level.

## Test plan
- Reset: drive Reset=0 mid-stream with 3 queued writes and iVidReq=1 → all outputs at reset values within the same cycle; after release oFifoLevel=0 and oRamWe stays 0 with no requests.
- Video latency: iVidReq=1 with addr 0x0010 at edge 5, RAM holds 3'b101 there → oRamAddr=0x0010 and oRamWe=0 after edge 5; oVidValid=1 and oVidData=3'b101 after edge 6, then oVidValid=0.
- CPU drain: 4 writes (0x0001..0x0004, data 1..4) on consecutive cycles, iVidReq=0 → oRamWe=1 on 4 consecutive cycles starting 2 edges after the first accept, in order; oFifoLevel returns to 0.
- Priority and full: iVidReq held high 10 cycles while the CPU offers 6 writes → oCpuReady drops after 4 accepts (oFifoLevel=4), oRamWe stays 0 throughout; after iVidReq falls, the 4 writes drain in order, then the remaining 2 are accepted.
- Simultaneous push/pop: with oFifoLevel=2 and iVidReq=0, accept one write on each of 5 cycles → oFifoLevel stays 2, and the pointers wrap correctly (data order preserved past index FIFO_DEPTH−1).
- No forwarding: queue a write of 3'b111 to 0x0020 while iVidReq=1 fetches 0x0020 (old value 3'b000) → oVidData=3'b000; a fetch after the write drains → 3'b111.
